// File: rtl/flush_ctrl_pkg.sv
// Shared types and constants for the writeback-driven flush/redirect controller.
// The counter step helper is used for both the in-flight counter and the drain counter.
package flush_ctrl_pkg;

  localparam int CNT_W           = 2;
  localparam int MAX_OUTSTANDING = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } flush_state_e;

  // Saturating up/down step: a simultaneous inc and dec cancel out.
  function automatic cnt_t cnt_step(input cnt_t c, input logic inc, input logic dec);
    cnt_t r;
    r = c;
    if (inc && !dec && (c != cnt_t'(MAX_OUTSTANDING))) begin
      r = c + cnt_t'(1);
    end else if (dec && !inc && (c != cnt_t'(0))) begin
      r = c - cnt_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/flush_ctrl_if.sv
// Bundle between writeback/fetch (master side) and the flush controller (slave side).
interface flush_ctrl_if;
  import flush_ctrl_pkg::*;

  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] ex_entry;
  logic [31:0] era;
  logic        inst_req_fire;
  logic        inst_data_ok;
  logic        redirect_ready;

  logic        stage_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_block;
  logic        discard_data;
  cnt_t        outstanding;

  modport master (
    output wb_ex, ertn_flush, ex_entry, era, inst_req_fire, inst_data_ok, redirect_ready,
    input  stage_flush, redirect_valid, redirect_pc, fetch_block, discard_data, outstanding
  );

  modport slave (
    input  wb_ex, ertn_flush, ex_entry, era, inst_req_fire, inst_data_ok, redirect_ready,
    output stage_flush, redirect_valid, redirect_pc, fetch_block, discard_data, outstanding
  );

endinterface

// File: rtl/flush_ctrl_inst_req_counter.sv
// In-flight fetch request counter; also exposes the value it will hold next cycle
// so the flush FSM can snapshot it including same-cycle fire/data_ok.
module inst_req_counter
  import flush_ctrl_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic fire,
  input  logic data_ok,
  output cnt_t count,
  output cnt_t count_next
);

  always_comb begin
    count_next = cnt_step(count, fire, data_ok);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/flush_ctrl.sv
// Flush controller: on an exception/ertn commit it flushes the pipeline, drains the
// fetch responses belonging to cancelled requests, then presents the redirect target.
module flush_ctrl
  import flush_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  flush_ctrl_if.slave  bus
);

  flush_state_e state, state_next;
  cnt_t         cancel_cnt, cancel_next;
  cnt_t         out_next;
  logic [31:0]  redirect_pc_q, pc_next;
  logic         flush_event;

  inst_req_counter u_inst_req_counter (
    .clk        (clk),
    .resetn     (resetn),
    .fire       (bus.inst_req_fire),
    .data_ok    (bus.inst_data_ok),
    .count      (bus.outstanding),
    .count_next (out_next)
  );

  assign flush_event = bus.wb_ex | bus.ertn_flush;

  always_comb begin
    state_next  = state;
    cancel_next = cancel_cnt;
    pc_next     = redirect_pc_q;
    unique case (state)
      IDLE: begin
        if (flush_event) begin
          pc_next     = bus.wb_ex ? bus.ex_entry : bus.era;
          cancel_next = out_next;
          state_next  = (out_next != cnt_t'(0)) ? DRAIN : REDIRECT;
        end
      end
      DRAIN: begin
        cancel_next = cnt_step(cancel_cnt, bus.inst_req_fire, bus.inst_data_ok);
        // Last cancelled response leaves only when no new request replaces it.
        if (bus.inst_data_ok && !bus.inst_req_fire && (cancel_cnt == cnt_t'(1))) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      cancel_cnt    <= '0;
      redirect_pc_q <= '0;
    end else begin
      state         <= state_next;
      cancel_cnt    <= cancel_next;
      redirect_pc_q <= pc_next;
    end
  end

  // Every control output is forced low while reset is held, even before the edge.
  assign bus.stage_flush    = resetn & flush_event & (state == IDLE);
  assign bus.redirect_valid = resetn & (state == REDIRECT);
  assign bus.fetch_block    = resetn & (state != IDLE);
  assign bus.discard_data   = resetn & (state == DRAIN) & bus.inst_data_ok;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Scoreboard bench for flush_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the flush protocol.
module tb_flush_ctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  flush_ctrl_if bus ();

  flush_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic        known;
    logic        sf;
    logic        dd;
    logic        rv;
    logic        fb;
    logic [1:0]  out;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: a flush is either inactive, waiting for cancelled responses, or
  // waiting for fetch to take the redirect.
  bit          m_known     = 0;
  int          m_inflight  = 0;
  bit          m_flushing  = 0;
  int          m_to_drop   = 0;
  logic [31:0] m_target    = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rn, input logic ex, input logic er,
                     input logic [31:0] ent, input logic [31:0] ra,
                     input logic f, input logic d, input logic rdy);
    exp_t e;
    bit   in_drain, in_redir;
    int   nxt;
    @(posedge clk);
    #1;
    resetn             = rn;
    bus.wb_ex          = ex;
    bus.ertn_flush     = er;
    bus.ex_entry       = ent;
    bus.era            = ra;
    bus.inst_req_fire  = f;
    bus.inst_data_ok   = d;
    bus.redirect_ready = rdy;

    in_drain = m_flushing && (m_to_drop > 0);
    in_redir = m_flushing && (m_to_drop == 0);
    e.known = m_known;
    e.sf    = rn & (ex | er) & !m_flushing;
    e.dd    = rn & in_drain & d;
    e.rv    = rn & in_redir;
    e.fb    = rn & m_flushing;
    e.out   = 2'(m_inflight);
    e.pc    = m_target;
    sb_q.push_back(e);

    if (!rn) begin
      m_known    = 1;
      m_inflight = 0;
      m_flushing = 0;
      m_to_drop  = 0;
      m_target   = 32'h0;
    end else begin
      nxt = m_inflight + (f ? 1 : 0) - (d ? 1 : 0);
      if (nxt > 3) nxt = 3;
      if (nxt < 0) nxt = 0;
      if (!m_flushing && (ex || er)) begin
        m_target   = ex ? ent : ra;
        m_flushing = 1;
        m_to_drop  = nxt;
      end else if (in_drain) begin
        m_to_drop = m_to_drop + (f ? 1 : 0) - (d ? 1 : 0);
        if (m_to_drop > 3) m_to_drop = 3;
      end else if (in_redir && rdy) begin
        m_flushing = 0;
      end
      m_inflight = nxt;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stage_flush",    32'(bus.stage_flush),    32'(e.sf));
        chk("discard_data",   32'(bus.discard_data),   32'(e.dd));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
        chk("fetch_block",    32'(bus.fetch_block),    32'(e.fb));
        if (e.known) begin
          chk("outstanding", 32'(bus.outstanding), 32'(e.out));
          chk("redirect_pc", bus.redirect_pc, e.pc);
        end
      end
    end
  end

  initial begin
    resetn             = 1'b0;
    bus.wb_ex          = 1'b0;
    bus.ertn_flush     = 1'b0;
    bus.ex_entry       = 32'h0;
    bus.era            = 32'h0;
    bus.inst_req_fire  = 1'b0;
    bus.inst_data_ok   = 1'b0;
    bus.redirect_ready = 1'b0;

    cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    cyc(0, 1, 0, 32'h1234, 32'h0, 1, 0, 1);
    idle(2);

    // Exception with nothing in flight: redirect the very next cycle.
    cyc(1, 1, 0, 32'h1C008000, 32'h0, 0, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    idle(1);

    // ertn with two requests in flight: both responses discarded first.
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    cyc(1, 0, 1, 32'h0, 32'h1C000100, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    idle(1);

    // Both commits together: exception entry wins.
    cyc(1, 1, 1, 32'h80, 32'h40, 0, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    idle(1);

    // Redirect stalled, a second commit is ignored.
    cyc(1, 1, 0, 32'h2000, 32'h0, 0, 0, 0);
    idle(5);
    cyc(1, 1, 0, 32'hDEAD0000, 32'h0, 0, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    idle(2);

    // Counter saturation.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 1, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    idle(1);

    // Reset in the middle of a drain abandons the redirect.
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    cyc(1, 1, 0, 32'h3000, 32'h0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 1);
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 13) == 0),
          ($urandom_range(0, 13) == 0),
          $urandom, $urandom,
          ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 9) < 4),
          $urandom_range(0, 1) == 1);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flush_ctrl.md
FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: resetn  input  1  synchronous, active-low reset.
REQ-003 SHALL have: wb_ex  input  1  exception commit from writeback, single-cycle.
REQ-004 SHALL have: ertn_flush  input  1  ertn commit from writeback, single-cycle.
REQ-005 SHALL have: ex_entry  input  32  exception entry address (CSR EENTRY).
REQ-006 SHALL have: era  input  32  return address (CSR ERA).
REQ-007 SHALL have: inst_req_fire  input  1  fetch request accepted (req & addr_ok).
REQ-008 SHALL have: inst_data_ok  input  1  fetch data returned.
REQ-009 SHALL have: redirect_ready  input  1  fetch accepts redirect.
REQ-010 SHALL have: stage_flush  output  1  flush pulse to all pipeline stages.
REQ-011 SHALL have: redirect_valid  output  1  redirect pending.
REQ-012 SHALL have: redirect_pc  output  32  redirect target.
REQ-013 SHALL have: fetch_block  output  1  inhibit new fetch requests.
REQ-014 SHALL have: discard_data  output  1  current inst_data_ok belongs to a cancelled request.
REQ-015 SHALL have: outstanding  output  2  in-flight fetch request count.

Function
REQ-016 outstanding SHALL increment on inst_req_fire only, decrement on inst_data_ok only, and hold when both or neither occur.
REQ-017 outstanding SHALL saturate at 3 and SHALL NOT decrement below 0.
REQ-018 FSM SHALL have states IDLE, DRAIN, REDIRECT.
REQ-019 stage_flush SHALL equal (wb_ex | ertn_flush) & (state==IDLE), combinationally, in the event cycle.
REQ-020 In IDLE on event, the FSM SHALL capture redirect_pc = wb_ex ? ex_entry : era; wb_ex has priority when both are asserted.
REQ-021 On event, cancel_cnt SHALL load the next-cycle outstanding value, including same-cycle fire/data_ok.
REQ-022 On event, the next state SHALL be DRAIN if the loaded cancel_cnt > 0, else REDIRECT.
REQ-023 In DRAIN, each inst_data_ok SHALL assert discard_data in the same cycle and decrement cancel_cnt.
REQ-024 DRAIN SHALL go to REDIRECT when inst_data_ok arrives with cancel_cnt==1.
REQ-025 An inst_req_fire in DRAIN SHALL increment cancel_cnt; with simultaneous data_ok, cancel_cnt SHALL hold.
REQ-026 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc stable until redirect_ready.
REQ-027 REDIRECT SHALL go to IDLE in the cycle after redirect_valid & redirect_ready.
REQ-028 fetch_block SHALL be 1 in DRAIN and REDIRECT, and 0 in IDLE.
REQ-029 wb_ex/ertn_flush outside IDLE SHALL be ignored: no stage_flush, redirect_pc unchanged.
REQ-030 discard_data SHALL be 0 in IDLE and REDIRECT.
REQ-031 Event-to-redirect_valid latency SHALL be 1 cycle with no outstanding requests, and 1 cycle after the last cancelled data_ok otherwise.

Reset
REQ-032 While resetn==0 at clk edge: state=IDLE, outstanding=0, cancel_cnt=0, redirect_pc=0.
REQ-033 During and after reset all outputs SHALL be 0: redirect_valid, fetch_block, discard_data, stage_flush (gated by resetn).
REQ-034 Reset mid-DRAIN/REDIRECT SHALL abandon the pending redirect with no redirect_valid afterwards.

Structure
REQ-035 Shared package SHALL hold state encoding (IDLE=0, DRAIN=1, REDIRECT=2), CNT_W=2, MAX_OUTSTANDING=3.
REQ-036 Outstanding counter SHALL be sub-module inst_req_counter (fire, data_ok -> count); FSM and target capture stay in flush_ctrl.

Verification
REQ-037 outstanding=0, wb_ex=1, ex_entry=0x1C008000 -> stage_flush=1 same cycle; next cycle redirect_valid=1, redirect_pc=0x1C008000, fetch_block=1.
REQ-038 Two requests fired, ertn_flush=1, era=0x1C000100 -> two data_ok with discard_data=1; redirect_valid rises the cycle after the second; pc=0x1C000100.
REQ-039 wb_ex and ertn_flush together, ex_entry=0x80, era=0x40 -> redirect_pc=0x80.
REQ-040 REDIRECT with redirect_ready held 0 for 5 cycles, then wb_ex pulse -> no stage_flush, redirect_pc unchanged; IDLE one cycle after ready=1.
REQ-041 Four consecutive fires, no data_ok -> outstanding=3 and holds; fire+data_ok same cycle -> holds 3.
REQ-042 resetn=0 in DRAIN with cancel_cnt=2 -> next cycle all outputs 0, state IDLE; later data_ok gives discard_data=0.
